// File: rtl/scpad_fe_arbiter.sv
// ----------------------------------------------------------------------------
// scpad_fe_arbiter
//
// Shares the single scratchpad body request port among NUM_FE frontend
// slices. A round-robin arbiter picks one frontend per cycle. The winning
// request is registered toward the body. Per-frontend credit counters limit
// each frontend to MAX_OUT outstanding requests. Body responses are routed
// back by ID. A drain mode blocks new grants until every outstanding
// request has returned.
//
// Ports
//   clk, n_rst          clock, synchronous active-low reset
//   fe_req_valid_i      per-frontend request valid            [NUM_FE]
//   fe_req_data_i       per-frontend payload, fe i at slice i [NUM_FE*REQ_W]
//   fe_stall_o          request valid but not granted          [NUM_FE]
//   body_req_valid_o    registered request valid toward body
//   body_req_data_o     registered request payload             [REQ_W]
//   body_req_id_o       owning frontend of the request         [ID_W]
//   body_req_ready_i    body accepts the registered request
//   body_res_valid_i    response valid from body
//   body_res_id_i       owning frontend of the response        [ID_W]
//   body_res_data_i     response payload                       [RES_W]
//   fe_res_valid_o      one-hot response valid                 [NUM_FE]
//   fe_res_data_o       response payload, broadcast            [RES_W]
//   drain_req_i         level request to drain
//   drain_done_o        drained: nothing outstanding, no grants
//   err_unexp_res_o     sticky: response for a frontend with zero credits
// ----------------------------------------------------------------------------
module scpad_fe_arbiter #(
   parameter int NUM_FE  = 2,
   parameter int ID_W    = $clog2(NUM_FE),
   parameter int REQ_W   = 64,
   parameter int RES_W   = 64,
   parameter int MAX_OUT = 4
) (
   input  logic                    clk,
   input  logic                    n_rst,
   input  logic [NUM_FE-1:0]       fe_req_valid_i,
   input  logic [NUM_FE*REQ_W-1:0] fe_req_data_i,
   output logic [NUM_FE-1:0]       fe_stall_o,
   output logic                    body_req_valid_o,
   output logic [REQ_W-1:0]        body_req_data_o,
   output logic [ID_W-1:0]         body_req_id_o,
   input  logic                    body_req_ready_i,
   input  logic                    body_res_valid_i,
   input  logic [ID_W-1:0]         body_res_id_i,
   input  logic [RES_W-1:0]        body_res_data_i,
   output logic [NUM_FE-1:0]       fe_res_valid_o,
   output logic [RES_W-1:0]        fe_res_data_o,
   input  logic                    drain_req_i,
   output logic                    drain_done_o,
   output logic                    err_unexp_res_o
);

   localparam int              CNT_W   = $clog2(MAX_OUT + 1);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_OUT);

   typedef enum logic [1:0] {
      ST_RUN   = 2'd0,
      ST_DRAIN = 2'd1,
      ST_DONE  = 2'd2
   } state_e;

   state_e            state_q, state_d;
   logic [ID_W-1:0]   rr_ptr_q, rr_ptr_d;
   logic [CNT_W-1:0]  cnt_q [NUM_FE];
   logic [CNT_W-1:0]  cnt_d [NUM_FE];
   logic              body_req_valid_q, body_req_valid_d;
   logic [REQ_W-1:0]  body_req_data_q, body_req_data_d;
   logic [ID_W-1:0]   body_req_id_q, body_req_id_d;
   logic              drain_done_q, drain_done_d;
   logic              err_q, err_d;

   logic [NUM_FE-1:0] res_hit;
   logic [NUM_FE-1:0] eligible;
   logic [NUM_FE-1:0] grant;
   logic              grant_any;
   logic [ID_W-1:0]   grant_id;
   logic [ID_W-1:0]   rr_idx;
   logic              slot_free;
   logic              grant_en;
   logic              idle_next;

   // ---------------------------------------------------------------------
   // Response routing (purely combinational)
   // ---------------------------------------------------------------------
   always_comb begin
      // NOTE: every variable gets a default before any conditional update,
      // so no path leaves it unassigned and no latch is inferred.
      res_hit = '0;
      for (int i = 0; i < NUM_FE; i++) begin
         res_hit[i] = body_res_valid_i && (body_res_id_i == ID_W'(i));
      end
   end

   assign fe_res_valid_o = res_hit;
   assign fe_res_data_o  = body_res_data_i;

   // ---------------------------------------------------------------------
   // Eligibility and round-robin grant
   // ---------------------------------------------------------------------
   // Grants are suppressed during reset and from the very cycle drain_req_i
   // rises, before the FSM has left RUN.
   assign slot_free = !body_req_valid_q || body_req_ready_i;
   assign grant_en  = n_rst && (state_q == ST_RUN) && !drain_req_i && slot_free;

   always_comb begin
      eligible = '0;
      for (int i = 0; i < NUM_FE; i++) begin
         // A response for i in this cycle returns a credit immediately, so a
         // frontend sitting at MAX_OUT may still win in that cycle.
         eligible[i] = grant_en && fe_req_valid_i[i] &&
                       ((cnt_q[i] < CNT_MAX) || res_hit[i]);
      end
   end

   always_comb begin
      grant     = '0;
      grant_any = 1'b0;
      grant_id  = '0;
      rr_idx    = '0;
      // NUM_FE is a power of two, so the ID_W-bit add wraps modulo NUM_FE.
      for (int k = 0; k < NUM_FE; k++) begin
         rr_idx = rr_ptr_q + ID_W'(k);
         if (!grant_any && eligible[rr_idx]) begin
            grant_any = 1'b1;
            grant_id  = rr_idx;
         end
      end
      if (grant_any) begin
         grant[grant_id] = 1'b1;
      end
   end

   assign fe_stall_o = fe_req_valid_i & ~grant;
   assign rr_ptr_d   = grant_any ? (grant_id + ID_W'(1)) : rr_ptr_q;

   // ---------------------------------------------------------------------
   // Output register, credits, error flag
   // ---------------------------------------------------------------------
   always_comb begin
      body_req_valid_d = body_req_valid_q;
      body_req_data_d  = body_req_data_q;
      body_req_id_d    = body_req_id_q;
      if (grant_any) begin
         body_req_valid_d = 1'b1;
         body_req_data_d  = fe_req_data_i[int'(grant_id)*REQ_W +: REQ_W];
         body_req_id_d    = grant_id;
      end else if (body_req_ready_i) begin
         body_req_valid_d = 1'b0;
      end
   end

   always_comb begin
      err_d = err_q;
      for (int i = 0; i < NUM_FE; i++) begin
         cnt_d[i] = cnt_q[i];
         if (grant[i] && !res_hit[i]) begin
            cnt_d[i] = cnt_q[i] + CNT_W'(1);
         end else if (!grant[i] && res_hit[i] && (cnt_q[i] != '0)) begin
            cnt_d[i] = cnt_q[i] - CNT_W'(1);
         end
         // The stray response is still forwarded; only the flag records it.
         if (res_hit[i] && (cnt_q[i] == '0)) begin
            err_d = 1'b1;
         end
      end
   end

   // ---------------------------------------------------------------------
   // Drain FSM
   // ---------------------------------------------------------------------
   // Completion looks at next-cycle credit and slot state, so drain_done_o
   // rises on the edge right after the last response returns.
   always_comb begin
      idle_next = !body_req_valid_d;
      for (int i = 0; i < NUM_FE; i++) begin
         if (cnt_d[i] != '0) begin
            idle_next = 1'b0;
         end
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         ST_RUN: begin
            if (drain_req_i) state_d = ST_DRAIN;
         end
         ST_DRAIN: begin
            if (!drain_req_i)   state_d = ST_RUN;
            else if (idle_next) state_d = ST_DONE;
         end
         ST_DONE: begin
            if (!drain_req_i) state_d = ST_RUN;
         end
         default: state_d = ST_RUN;
      endcase
      drain_done_d = (state_d == ST_DONE);
   end

   // ---------------------------------------------------------------------
   // State registers
   // ---------------------------------------------------------------------
   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values, independent of statement order.
   always_ff @(posedge clk) begin
      if (!n_rst) begin
         state_q          <= ST_RUN;
         rr_ptr_q         <= '0;
         body_req_valid_q <= 1'b0;
         body_req_data_q  <= '0;
         body_req_id_q    <= '0;
         drain_done_q     <= 1'b0;
         err_q            <= 1'b0;
         // NOTE: the credit array is a handful of flops, not a RAM, so it is
         // reset explicitly; in-flight credits are discarded on reset.
         for (int i = 0; i < NUM_FE; i++) begin
            cnt_q[i] <= '0;
         end
      end else begin
         state_q          <= state_d;
         rr_ptr_q         <= rr_ptr_d;
         body_req_valid_q <= body_req_valid_d;
         body_req_data_q  <= body_req_data_d;
         body_req_id_q    <= body_req_id_d;
         drain_done_q     <= drain_done_d;
         err_q            <= err_d;
         for (int i = 0; i < NUM_FE; i++) begin
            cnt_q[i] <= cnt_d[i];
         end
      end
   end

   assign body_req_valid_o = body_req_valid_q;
   assign body_req_data_o  = body_req_data_q;
   assign body_req_id_o    = body_req_id_q;
   assign drain_done_o     = drain_done_q;
   assign err_unexp_res_o  = err_q;

endmodule

// File: tb/tb_scpad_fe_arbiter.sv
// ----------------------------------------------------------------------------
// tb_scpad_fe_arbiter
//
// Self-checking bench for scpad_fe_arbiter (NUM_FE=2, MAX_OUT=4).
// Expected body requests are queued when the bench drives a request it
// expects to be granted; a monitor pops and compares on every body accept.
// Inputs change 1 time unit after the rising edge; combinational outputs
// are sampled 1 unit later, registered outputs right after the edge.
// ----------------------------------------------------------------------------
module tb_scpad_fe_arbiter;

   localparam int NUM_FE  = 2;
   localparam int ID_W    = 1;
   localparam int REQ_W   = 64;
   localparam int RES_W   = 64;
   localparam int MAX_OUT = 4;

   logic                    clk = 1'b0;
   logic                    n_rst;
   logic [NUM_FE-1:0]       fe_req_valid;
   logic [NUM_FE*REQ_W-1:0] fe_req_data;
   logic [NUM_FE-1:0]       fe_stall;
   logic                    body_req_valid;
   logic [REQ_W-1:0]        body_req_data;
   logic [ID_W-1:0]         body_req_id;
   logic                    body_req_ready;
   logic                    body_res_valid;
   logic [ID_W-1:0]         body_res_id;
   logic [RES_W-1:0]        body_res_data;
   logic [NUM_FE-1:0]       fe_res_valid;
   logic [RES_W-1:0]        fe_res_data;
   logic                    drain_req;
   logic                    drain_done;
   logic                    err_unexp_res;

   typedef struct packed {
      logic [ID_W-1:0]  id;
      logic [REQ_W-1:0] data;
   } exp_req_t;

   exp_req_t sb_q[$];
   int       checks = 0;
   int       errors = 0;

   always #5 clk = ~clk;

   scpad_fe_arbiter #(
      .NUM_FE (NUM_FE),
      .ID_W   (ID_W),
      .REQ_W  (REQ_W),
      .RES_W  (RES_W),
      .MAX_OUT(MAX_OUT)
   ) dut (
      .clk             (clk),
      .n_rst           (n_rst),
      .fe_req_valid_i  (fe_req_valid),
      .fe_req_data_i   (fe_req_data),
      .fe_stall_o      (fe_stall),
      .body_req_valid_o(body_req_valid),
      .body_req_data_o (body_req_data),
      .body_req_id_o   (body_req_id),
      .body_req_ready_i(body_req_ready),
      .body_res_valid_i(body_res_valid),
      .body_res_id_i   (body_res_id),
      .body_res_data_i (body_res_data),
      .fe_res_valid_o  (fe_res_valid),
      .fe_res_data_o   (fe_res_data),
      .drain_req_i     (drain_req),
      .drain_done_o    (drain_done),
      .err_unexp_res_o (err_unexp_res)
   );

   task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      #1;
   endtask

   task automatic set_data(input int fe, input logic [REQ_W-1:0] v);
      fe_req_data[fe*REQ_W +: REQ_W] = v;
   endtask

   task automatic push_exp(input logic [ID_W-1:0] id, input logic [REQ_W-1:0] d);
      exp_req_t e;
      e.id   = id;
      e.data = d;
      sb_q.push_back(e);
   endtask

   // Scoreboard: a request leaves the DUT when valid and ready meet at an edge.
   always @(negedge clk) begin : monitor
      exp_req_t e;
      if (n_rst && body_req_valid && body_req_ready) begin
         check("sb_pending", 128'(sb_q.size() != 0), 128'd1);
         if (sb_q.size() != 0) begin
            e = sb_q.pop_front();
            check("acc_id", 128'(body_req_id), 128'(e.id));
            check("acc_data", 128'(body_req_data), 128'(e.data));
         end
      end
   end

   // One reset edge; reset discards anything still in flight.
   task automatic do_reset();
      n_rst        = 1'b0;
      fe_req_valid = 2'b11;
      settle();
      check("rst_stall_follows_valid", 128'(fe_stall), 128'd3);
      step();
      sb_q.delete();
      n_rst          = 1'b1;
      fe_req_valid   = '0;
      body_res_valid = 1'b0;
      drain_req      = 1'b0;
      body_req_ready = 1'b1;
      check("rst_body_valid", 128'(body_req_valid), 128'd0);
      check("rst_body_data", 128'(body_req_data), 128'd0);
      check("rst_body_id", 128'(body_req_id), 128'd0);
      check("rst_drain_done", 128'(drain_done), 128'd0);
      check("rst_err", 128'(err_unexp_res), 128'd0);
   endtask

   initial begin : stim
      logic [ID_W-1:0] g;
      logic [1:0]      exp_st;

      n_rst          = 1'b0;
      fe_req_valid   = '0;
      fe_req_data    = '0;
      body_req_ready = 1'b1;
      body_res_valid = 1'b0;
      body_res_id    = '0;
      body_res_data  = '0;
      drain_req      = 1'b0;
      step();
      do_reset();

      // ---- Round-robin, no backpressure: grants 0,1,0,1 ----
      for (int k = 0; k < 4; k++) begin
         g            = ID_W'(k % 2);
         exp_st       = g ? 2'b01 : 2'b10;
         fe_req_valid = 2'b11;
         set_data(0, 64'hA000 + 64'(k));
         set_data(1, 64'hB000 + 64'(k));
         settle();
         check("rr_stall", 128'(fe_stall), 128'(exp_st));
         push_exp(g, g ? 64'hB000 + 64'(k) : 64'hA000 + 64'(k));
         step();
         check("rr_valid", 128'(body_req_valid), 128'd1);
         check("rr_id", 128'(body_req_id), 128'(g));
      end
      fe_req_valid = '0;
      step();
      check("rr_idle_valid", 128'(body_req_valid), 128'd0);

      // ---- Backpressure hold ----
      do_reset();
      fe_req_valid = 2'b01;
      set_data(0, 64'hA5);
      settle();
      check("bp_fe0_stall", 128'(fe_stall), 128'd0);
      push_exp(1'b0, 64'hA5);
      step();
      body_req_ready = 1'b0;
      fe_req_valid   = 2'b10;
      set_data(1, 64'h5A);
      for (int k = 0; k < 3; k++) begin
         settle();
         check("bp_fe1_stall", 128'(fe_stall), 128'd2);
         step();
         check("bp_hold_valid", 128'(body_req_valid), 128'd1);
         check("bp_hold_data", 128'(body_req_data), 128'hA5);
      end
      body_req_ready = 1'b1;
      settle();
      check("bp_fe1_accept", 128'(fe_stall), 128'd0);
      push_exp(1'b1, 64'h5A);
      step();
      check("bp_fe1_id", 128'(body_req_id), 128'd1);
      fe_req_valid = '0;
      step();

      // ---- Credit limit ----
      do_reset();
      fe_req_valid = 2'b01;
      for (int k = 0; k < 4; k++) begin
         set_data(0, 64'hC000 + 64'(k));
         settle();
         check("cr_grant_stall", 128'(fe_stall), 128'd0);
         push_exp(1'b0, 64'hC000 + 64'(k));
         step();
      end
      set_data(0, 64'hC004);
      settle();
      check("cr_fifth_stall", 128'(fe_stall), 128'd1);
      step();
      body_res_valid = 1'b1;
      body_res_id    = 1'b0;
      body_res_data  = 64'hD0;
      settle();
      check("cr_res_route", 128'(fe_res_valid), 128'd1);
      check("cr_res_data", 128'(fe_res_data), 128'hD0);
      check("cr_res_frees_credit", 128'(fe_stall), 128'd0);
      push_exp(1'b0, 64'hC004);
      step();
      body_res_valid = 1'b0;
      set_data(0, 64'hC005);
      settle();
      check("cr_still_full", 128'(fe_stall), 128'd1);
      step();
      fe_req_valid = '0;
      step();

      // ---- Drain with two outstanding on fe1 ----
      do_reset();
      fe_req_valid = 2'b10;
      for (int k = 0; k < 2; k++) begin
         set_data(1, 64'hE0 + 64'(k));
         settle();
         check("dr_fill_stall", 128'(fe_stall), 128'd0);
         push_exp(1'b1, 64'hE0 + 64'(k));
         step();
      end
      fe_req_valid = '0;
      step();
      drain_req    = 1'b1;
      fe_req_valid = 2'b11;
      settle();
      check("dr_block_stall", 128'(fe_stall), 128'd3);
      step();
      check("dr_not_done_0", 128'(drain_done), 128'd0);
      body_res_valid = 1'b1;
      body_res_id    = 1'b1;
      settle();
      check("dr_res_route", 128'(fe_res_valid), 128'd2);
      step();
      body_res_valid = 1'b0;
      check("dr_not_done_1", 128'(drain_done), 128'd0);
      step();
      check("dr_not_done_2", 128'(drain_done), 128'd0);
      body_res_valid = 1'b1;
      settle();
      check("dr_still_blocked", 128'(fe_stall), 128'd3);
      step();
      body_res_valid = 1'b0;
      check("dr_done", 128'(drain_done), 128'd1);
      drain_req    = 1'b0;
      fe_req_valid = 2'b01;
      set_data(0, 64'hF0);
      settle();
      check("dr_done_cycle_stall", 128'(fe_stall), 128'd1);
      step();
      check("dr_done_cleared", 128'(drain_done), 128'd0);
      settle();
      check("dr_resume_grant", 128'(fe_stall), 128'd0);
      push_exp(1'b0, 64'hF0);
      step();
      check("dr_resume_valid", 128'(body_req_valid), 128'd1);
      fe_req_valid = '0;
      step();

      // ---- Unexpected response ----
      do_reset();
      body_res_valid = 1'b1;
      body_res_id    = 1'b1;
      body_res_data  = 64'hBEEF;
      settle();
      check("ur_route", 128'(fe_res_valid), 128'd2);
      check("ur_data", 128'(fe_res_data), 128'hBEEF);
      check("ur_err_not_yet", 128'(err_unexp_res), 128'd0);
      step();
      body_res_valid = 1'b0;
      check("ur_err_set", 128'(err_unexp_res), 128'd1);
      step();
      step();
      check("ur_err_sticky", 128'(err_unexp_res), 128'd1);
      // A drain completes only if fe1's counter stayed at zero.
      drain_req = 1'b1;
      step();
      step();
      check("ur_cnt_zero_drain", 128'(drain_done), 128'd1);
      drain_req = 1'b0;
      step();
      check("ur_drain_exit", 128'(drain_done), 128'd0);
      check("ur_err_still", 128'(err_unexp_res), 128'd1);

      // ---- Reset mid-operation: build cnt0=2, cnt1=3 with a pending request ----
      for (int k = 0; k < 4; k++) begin
         g            = ID_W'(k % 2);
         exp_st       = g ? 2'b01 : 2'b10;
         fe_req_valid = 2'b11;
         set_data(0, 64'h1000 + 64'(k));
         set_data(1, 64'h2000 + 64'(k));
         settle();
         check("mr_fill_stall", 128'(fe_stall), 128'(exp_st));
         push_exp(g, g ? 64'h2000 + 64'(k) : 64'h1000 + 64'(k));
         step();
      end
      fe_req_valid = 2'b10;
      set_data(1, 64'h77);
      settle();
      check("mr_fe1_third", 128'(fe_stall), 128'd0);
      push_exp(1'b1, 64'h77);
      step();
      fe_req_valid   = '0;
      body_req_ready = 1'b0;
      step();
      check("mr_pending_valid", 128'(body_req_valid), 128'd1);
      do_reset();
      drain_req = 1'b1;
      step();
      step();
      check("mr_cnt_cleared_drain", 128'(drain_done), 128'd1);
      drain_req = 1'b0;
      step();
      fe_req_valid = 2'b11;
      set_data(0, 64'h3000);
      set_data(1, 64'h3001);
      settle();
      check("mr_rr_ptr_zero", 128'(fe_stall), 128'd2);
      push_exp(1'b0, 64'h3000);
      step();
      check("mr_grant_id", 128'(body_req_id), 128'd0);
      fe_req_valid = '0;
      step();
      step();

      check("sb_empty", 128'(sb_q.size()), 128'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
